// File: rtl/key_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_mode_ctrl
// Description : Debounced pushbutton front-end; short press steps the 2-bit
//               LED mode, long press forces mode 0.
// Revision    : 1.0 - initial release
// ============================================================================
module key_mode_ctrl #(
    parameter int DEB_CYCLES  = 800_000,
    parameter int LONG_CYCLES = 40_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output logic [1:0] ctrl,
    output logic       key_down,
    output logic       short_pulse,
    output logic       long_pulse
);

    localparam int c_DEB_W  = $clog2(DEB_CYCLES);
    localparam int c_HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [c_DEB_W-1:0]  c_DEB_MAX  = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_CYCLES - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE  = c_DEB_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HELD = 2'd1;
    localparam logic [1:0] S_LONG = 2'd2;

    logic                r_sync1;
    logic                r_key_s;
    logic                r_key_db;
    logic                r_key_down;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [1:0]          r_state;
    logic [1:0]          r_ctrl;
    logic                r_short;
    logic                r_long;

    // Two-flop synchroniser, reset to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_key_s <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_key_s <= r_sync1;
        end
    end

    // key_down is kept as its own flop so no output sits behind an inverter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_db   <= 1'b1;
            r_key_down <= 1'b0;
            r_deb_cnt  <= '0;
        end else if (r_key_s == r_key_db) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_DEB_MAX) begin
            r_key_db   <= r_key_s;
            r_key_down <= ~r_key_s;
            r_deb_cnt  <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_ctrl     <= 2'd0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_short <= 1'b0;
            r_long  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_key_db) begin
                        r_state    <= S_HELD;
                        r_hold_cnt <= '0;
                    end
                end
                S_HELD: begin
                    // Release wins over the long threshold on the same cycle
                    if (r_key_db) begin
                        r_ctrl  <= r_ctrl + 2'd1;
                        r_short <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_hold_cnt == c_HOLD_MAX) begin
                        r_ctrl  <= 2'd0;
                        r_long  <= 1'b1;
                        r_state <= S_LONG;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
                    end
                end
                S_LONG: begin
                    if (r_key_db) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl        = r_ctrl;
    assign key_down    = r_key_down;
    assign short_pulse = r_short;
    assign long_pulse  = r_long;

endmodule
`default_nettype wire
